// File: rtl/nonce_scanner_if.sv
// Miner-side handshake of the nonce scanner: the scanner drives reset/start/nonce,
// the miner answers with done and the resulting hash.
interface nonce_scanner_if;
  logic         miner_reset;
  logic         miner_start;
  logic [31:0]  miner_nonce;
  logic         miner_done;
  logic [255:0] miner_hash;

  modport master (output miner_reset, miner_start, miner_nonce,
                  input  miner_done, miner_hash);
  modport slave  (input  miner_reset, miner_start, miner_nonce,
                  output miner_done, miner_hash);
endinterface

// File: rtl/nonce_scanner.sv
// Job controller in front of the miner: expands compact difficulty bits into a
// 256-bit target, then sweeps a (possibly wrapping) nonce range until a hit or exhaustion.
module nonce_scanner #(
  parameter int unsigned NONCE_STRIDE    = 1,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_start,
  input  logic         job_abort,
  input  logic [31:0]  bits,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         error,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic [255:0] target,
  output logic [31:0]  hashes_done,
  nonce_scanner_if.master miner
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 32;
  localparam int WD_W      = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [31:0]     STRIDE  = 32'(NONCE_STRIDE);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_LAUNCH, S_WAIT, S_CHECK, S_CLEAR, S_FOUND, S_EXHAUSTED, S_ERROR
  } state_t;

  typedef struct packed {
    logic [31:0] bits;
    logic [31:0] first;
    logic [31:0] last;
  } job_t;

  state_t          state_q, state_d;
  job_t            job_q;
  logic [31:0]     cur_q;
  logic [255:0]    hash_q;
  logic [WD_W-1:0] wd_q;

  // Compact target decode: mantissa placed at byte offset (E-3), zero-filled.
  logic [7:0]   exp_e;
  logic [23:0]  mant;
  logic         dec_bad;
  logic [255:0] dec_target;

  assign exp_e   = job_q.bits[31:24];
  assign mant    = job_q.bits[23:0];
  assign dec_bad = mant[23] | (mant == 24'd0) | (exp_e > 8'd32);

  always_comb begin
    if (exp_e >= 8'd3) dec_target = {232'd0, mant} << {exp_e - 8'd3, 3'b000};
    else               dec_target = {232'd0, mant} >> {8'd3 - exp_e, 3'b000};
  end

  // hash <= target, evaluated lane-wise; the most significant unequal lane decides.
  logic [NUM_LANES-1:0][VEC_W-1:0] hash_l, tgt_l;
  logic [NUM_LANES-1:0]            gt_v, eq_v;
  logic                            hash_le;

  assign hash_l = hash_q;
  assign tgt_l  = target;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign gt_v[i] = hash_l[i] > tgt_l[i];
    assign eq_v[i] = hash_l[i] == tgt_l[i];
  end

  always_comb begin
    hash_le = 1'b1;
    for (int i = 0; i < NUM_LANES; i++)
      if (!eq_v[i]) hash_le = !gt_v[i];
  end

  logic [31:0] rem;
  logic        wd_hit;

  assign rem    = job_q.last - cur_q;
  assign wd_hit = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    if (job_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR:
          if (job_start) state_d = S_DECODE;
        S_DECODE: state_d = dec_bad ? S_ERROR : S_LAUNCH;
        S_LAUNCH: state_d = S_WAIT;
        S_WAIT: begin
          if (miner.miner_done) state_d = S_CHECK;
          else if (wd_hit)      state_d = S_ERROR;
        end
        S_CHECK: begin
          if (hash_le)              state_d = S_FOUND;
          else if (rem < STRIDE)    state_d = S_EXHAUSTED;
          else                      state_d = S_CLEAR;
        end
        S_CLEAR: state_d = S_LAUNCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy              <= 1'b0;
      found             <= 1'b0;
      exhausted         <= 1'b0;
      error             <= 1'b0;
      result_nonce      <= '0;
      result_hash       <= '0;
      target            <= '0;
      hashes_done       <= '0;
      miner.miner_reset <= 1'b1;
      miner.miner_start <= 1'b0;
      miner.miner_nonce <= '0;
      job_q             <= '0;
      cur_q             <= '0;
      hash_q            <= '0;
      wd_q              <= '0;
    end else begin
      busy              <= state_d inside {S_DECODE, S_LAUNCH, S_WAIT, S_CHECK, S_CLEAR};
      found             <= (state_d == S_FOUND);
      exhausted         <= (state_d == S_EXHAUSTED);
      error             <= (state_d == S_ERROR);
      miner.miner_start <= state_d inside {S_LAUNCH, S_WAIT, S_CHECK};
      miner.miner_reset <= !(state_d inside {S_LAUNCH, S_WAIT, S_CHECK});

      if (state_d == S_DECODE) begin
        job_q        <= '{bits: bits, first: nonce_first, last: nonce_last};
        cur_q        <= nonce_first;
        hashes_done  <= '0;
        result_nonce <= '0;
        result_hash  <= '0;
      end

      if (state_q == S_DECODE && state_d == S_LAUNCH) target <= dec_target;

      if (state_d == S_LAUNCH) begin
        miner.miner_nonce <= cur_q;
        wd_q              <= '0;
      end else if (state_q == S_WAIT) begin
        wd_q <= wd_q + WD_W'(1);
      end

      // Gated on the next state so an abort in the same cycle drops the result.
      if (state_q == S_WAIT && state_d == S_CHECK) begin
        hash_q <= miner.miner_hash;
        if (hashes_done != 32'hFFFF_FFFF) hashes_done <= hashes_done + 32'd1;
      end

      if (state_q == S_CHECK) begin
        if (state_d == S_FOUND) begin
          result_nonce <= cur_q;
          result_hash  <= hash_q;
        end
        if (state_d == S_CLEAR) cur_q <= cur_q + STRIDE;
      end
    end
  end
endmodule

// File: tb/tb_nonce_scanner.sv
// Scoreboarded bench for nonce_scanner: scripted miner stubs, expected launches and
// job outcomes queued at issue time and popped by per-DUT monitors.
module tb_nonce_scanner;
  typedef struct {
    logic [2:0]   flg;   // {found, exhausted, error}
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic [31:0]  hd;
    logic         chk_t;
    logic [255:0] tgt;
  } res_t;

  logic clk = 1'b0, reset = 1'b0;
  logic job_start = 1'b0, job_start_b = 1'b0, job_abort = 1'b0;
  logic [31:0] bits = '0, nonce_first = '0, nonce_last = '0;
  logic busy_a, found_a, exh_a, err_a, busy_b, found_b, exh_b, err_b;
  logic [31:0]  rn_a, hd_a, rn_b, hd_b;
  logic [255:0] rh_a, tg_a, rh_b, tg_b;
  logic stub_hang = 1'b0, win_en = 1'b0;
  logic [31:0]  win_nonce = '0;
  logic [255:0] win_hash = '0;
  logic [2:0] cnt_a, cnt_b;
  logic a_sp = 1'b0, a_tp = 1'b0, b_sp = 1'b0, b_tp = 1'b0;
  int n_vec = 0, n_err = 0;
  logic [31:0] nq_a[$], nq_b[$];
  res_t rq_a[$], rq_b[$];
  logic [255:0] tgt1, tgt2, tgt3;
  logic [31:0] bad_bits[3];

  nonce_scanner_if ma();
  nonce_scanner_if mb();

  always #5 clk = ~clk;

  nonce_scanner u_a (
    .clk(clk), .reset(reset), .job_start(job_start), .job_abort(job_abort),
    .bits(bits), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .busy(busy_a), .found(found_a), .exhausted(exh_a), .error(err_a),
    .result_nonce(rn_a), .result_hash(rh_a), .target(tg_a), .hashes_done(hd_a),
    .miner(ma));

  nonce_scanner #(.NONCE_STRIDE(2), .WATCHDOG_CYCLES(16)) u_b (
    .clk(clk), .reset(reset), .job_start(job_start_b), .job_abort(job_abort),
    .bits(bits), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .busy(busy_b), .found(found_b), .exhausted(exh_b), .error(err_b),
    .result_nonce(rn_b), .result_hash(rh_b), .target(tg_b), .hashes_done(hd_b),
    .miner(mb));

  function automatic logic [255:0] stub_hash(input logic [31:0] n);
    return (win_en && n == win_nonce) ? win_hash : {256{1'b1}};
  endfunction

  // Miner stubs: done 5 cycles after start, held until miner_reset.
  always @(posedge clk) begin
    if (ma.miner_reset) begin
      cnt_a <= '0; ma.miner_done <= 1'b0; ma.miner_hash <= '0;
    end else if (ma.miner_start && !ma.miner_done && !stub_hang) begin
      if (cnt_a == 3'd4) begin ma.miner_done <= 1'b1; ma.miner_hash <= stub_hash(ma.miner_nonce); end
      else cnt_a <= cnt_a + 3'd1;
    end
  end

  always @(posedge clk) begin
    if (mb.miner_reset) begin
      cnt_b <= '0; mb.miner_done <= 1'b0; mb.miner_hash <= '0;
    end else if (mb.miner_start && !mb.miner_done && !stub_hang) begin
      if (cnt_b == 3'd4) begin mb.miner_done <= 1'b1; mb.miner_hash <= stub_hash(mb.miner_nonce); end
      else cnt_b <= cnt_b + 3'd1;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++; n_err++;
    $display("FAIL %s: event unexpected or not seen in time", nm);
  endtask

  task automatic mon_res(input string t, input res_t e, input logic [2:0] flg,
                         input logic [31:0] rn, input logic [255:0] rh, input logic [31:0] hd,
                         input logic [255:0] tg, input logic ms, input logic mr);
    chk({t, "_flags"}, 256'(flg), 256'(e.flg));
    if (e.flg[2]) begin
      chk({t, "_rnonce"}, 256'(rn), 256'(e.nonce));
      chk({t, "_rhash"}, rh, e.hash);
    end
    chk({t, "_hashes"}, 256'(hd), 256'(e.hd));
    if (e.chk_t) chk({t, "_target"}, tg, e.tgt);
    chk({t, "_mstart"}, 256'(ms), 256'd0);
    chk({t, "_mreset"}, 256'(mr), 256'd1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ma.miner_start && !a_sp) begin
        if (nq_a.size() == 0) miss("a_launch_unexpected");
        else chk("a_nonce", 256'(ma.miner_nonce), 256'(nq_a.pop_front()));
      end
      if ((found_a | exh_a | err_a) && !a_tp) begin
        if (rq_a.size() == 0) miss("a_result_unexpected");
        else mon_res("a", rq_a.pop_front(), {found_a, exh_a, err_a}, rn_a, rh_a, hd_a, tg_a,
                     ma.miner_start, ma.miner_reset);
      end
    end
    a_sp = ma.miner_start;
    a_tp = found_a | exh_a | err_a;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mb.miner_start && !b_sp) begin
        if (nq_b.size() == 0) miss("b_launch_unexpected");
        else chk("b_nonce", 256'(mb.miner_nonce), 256'(nq_b.pop_front()));
      end
      if ((found_b | exh_b | err_b) && !b_tp) begin
        if (rq_b.size() == 0) miss("b_result_unexpected");
        else mon_res("b", rq_b.pop_front(), {found_b, exh_b, err_b}, rn_b, rh_b, hd_b, tg_b,
                     mb.miner_start, mb.miner_reset);
      end
    end
    b_sp = mb.miner_start;
    b_tp = found_b | exh_b | err_b;
  end

  task automatic exp_res(input bit b, input logic [2:0] flg, input logic [31:0] nonce,
                         input logic [255:0] hash, input logic [31:0] hd,
                         input logic chk_t, input logic [255:0] tgt);
    res_t r;
    r.flg = flg; r.nonce = nonce; r.hash = hash; r.hd = hd; r.chk_t = chk_t; r.tgt = tgt;
    if (b) rq_b.push_back(r); else rq_a.push_back(r);
  endtask

  task automatic push_n(input bit b, input logic [31:0] n);
    if (b) nq_b.push_back(n); else nq_a.push_back(n);
  endtask

  task automatic start_job(input bit b, input logic [31:0] bt, input logic [31:0] f, input logic [31:0] l);
    bits = bt; nonce_first = f; nonce_last = l;
    if (b) job_start_b = 1'b1; else job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0; job_start_b = 1'b0;
  endtask

  function automatic logic term(input bit b);
    return b ? (found_b | exh_b | err_b) : (found_a | exh_a | err_a);
  endfunction

  task automatic wait_term(input bit b, input int budget, input string nm);
    int i = 0;
    while (!term(b) && i < budget) begin @(negedge clk); i++; end
    if (!term(b)) miss(nm);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;
    tgt1 = 256'hFFFF << 208;
    tgt2 = 256'h123456;
    tgt3 = 256'h80;
    bad_bits[0] = 32'h21000001;
    bad_bits[1] = 32'h03800000;
    bad_bits[2] = 32'h03000000;

    #2 reset = 1'b1;
    #1;
    chk("rst_busy",   256'(busy_a), 256'd0);
    chk("rst_flags",  256'({found_a, exh_a, err_a}), 256'd0);
    chk("rst_mreset", 256'(ma.miner_reset), 256'd1);
    chk("rst_mstart", 256'(ma.miner_start), 256'd0);
    chk("rst_hashes", 256'(hd_a), 256'd0);
    chk("rst_target", tg_a, 256'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Hit on 7 with hash == target; a job_start mid-job must be ignored.
    win_en = 1'b1; win_nonce = 32'd7; win_hash = tgt1;
    push_n(0, 32'd5); push_n(0, 32'd6); push_n(0, 32'd7);
    exp_res(0, 3'b100, 32'd7, tgt1, 32'd3, 1'b1, tgt1);
    start_job(0, 32'h1d00ffff, 32'd5, 32'd10);
    repeat (3) @(negedge clk);
    bits = 32'h03800000; nonce_first = 32'd999; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    wait_term(0, 500, "found_timeout");

    // Single-nonce range, hash just under target.
    win_nonce = 32'd40; win_hash = 256'h123455;
    push_n(0, 32'd40);
    exp_res(0, 3'b100, 32'd40, 256'h123455, 32'd1, 1'b1, tgt2);
    start_job(0, 32'h03123456, 32'd40, 32'd40);
    wait_term(0, 200, "single_timeout");

    // Negative exponent decode; hash one above target still misses.
    win_nonce = 32'd52; win_hash = 256'h81;
    push_n(0, 32'd50); push_n(0, 32'd51); push_n(0, 32'd52);
    exp_res(0, 3'b010, 32'd0, 256'd0, 32'd3, 1'b1, tgt3);
    start_job(0, 32'h02008000, 32'd50, 32'd52);
    wait_term(0, 500, "tgt80_timeout");
    win_en = 1'b0;

    // Range wrapping through 0xFFFFFFFF, stride 1 then stride 2.
    push_n(0, 32'hFFFFFFFE); push_n(0, 32'hFFFFFFFF); push_n(0, 32'd0); push_n(0, 32'd1);
    exp_res(0, 3'b010, 32'd0, 256'd0, 32'd4, 1'b1, tgt1);
    start_job(0, 32'h1d00ffff, 32'hFFFFFFFE, 32'd1);
    wait_term(0, 500, "wrap_a_timeout");

    push_n(1, 32'hFFFFFFFE); push_n(1, 32'd0);
    exp_res(1, 3'b010, 32'd0, 256'd0, 32'd2, 1'b1, tgt1);
    start_job(1, 32'h1d00ffff, 32'hFFFFFFFE, 32'd1);
    wait_term(1, 500, "wrap_b_timeout");

    // Bad compact bits: error right after the single DECODE cycle, no launch.
    for (int k = 0; k < 3; k++) begin
      exp_res(0, 3'b001, 32'd0, 256'd0, 32'd0, 1'b0, 256'd0);
      start_job(0, bad_bits[k], 32'd1, 32'd9);
      chk("bad_decode_busy", 256'(busy_a), 256'd1);
      chk("bad_decode_err",  256'(err_a),  256'd0);
      @(negedge clk);
      chk("bad_err",  256'(err_a),  256'd1);
      chk("bad_busy", 256'(busy_a), 256'd0);
      @(negedge clk);
    end

    // Miner never answers: watchdog trips WATCHDOG_CYCLES after WAIT entry.
    stub_hang = 1'b1;
    push_n(0, 32'd70);
    exp_res(0, 3'b001, 32'd0, 256'd0, 32'd0, 1'b0, 256'd0);
    start_job(0, 32'h1d00ffff, 32'd70, 32'd80);
    cnt = 0;
    while (!ma.miner_start && cnt < 10) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (!err_a && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("wd_start_to_error", 256'(cnt), 256'd1025);
    @(negedge clk);
    stub_hang = 1'b0;

    // Abort in WAIT (with a simultaneous start) keeps the completed count.
    push_n(0, 32'd20); push_n(0, 32'd21);
    start_job(0, 32'h1d00ffff, 32'd20, 32'd30);
    cnt = 0;
    while (!(ma.miner_start && ma.miner_nonce == 32'd21) && cnt < 100) begin @(negedge clk); cnt++; end
    if (!(ma.miner_start && ma.miner_nonce == 32'd21)) miss("abort_launch_timeout");
    repeat (2) @(negedge clk);
    job_abort = 1'b1; job_start = 1'b1;
    @(negedge clk);
    chk("abort_busy",   256'(busy_a), 256'd0);
    chk("abort_mstart", 256'(ma.miner_start), 256'd0);
    chk("abort_mreset", 256'(ma.miner_reset), 256'd1);
    chk("abort_hashes", 256'(hd_a), 256'd1);
    chk("abort_flags",  256'({found_a, exh_a, err_a}), 256'd0);
    job_abort = 1'b0; job_start = 1'b0;
    @(negedge clk);
    chk("abort_start_dropped", 256'(busy_a), 256'd0);

    // Asynchronous reset between clock edges.
    stub_hang = 1'b1;
    push_n(0, 32'd60);
    start_job(0, 32'h1d00ffff, 32'd60, 32'd61);
    cnt = 0;
    while (!ma.miner_start && cnt < 10) begin @(negedge clk); cnt++; end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy",   256'(busy_a), 256'd0);
    chk("arst_mstart", 256'(ma.miner_start), 256'd0);
    chk("arst_mreset", 256'(ma.miner_reset), 256'd1);
    chk("arst_b_exh",  256'(exh_b), 256'd0);
    @(negedge clk);
    reset = 1'b0; stub_hang = 1'b0;
    repeat (2) @(negedge clk);

    chk("a_nonce_left",  256'(nq_a.size()), 256'd0);
    chk("a_result_left", 256'(rq_a.size()), 256'd0);
    chk("b_nonce_left",  256'(nq_b.size()), 256'd0);
    chk("b_result_left", 256'(rq_b.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
